// File: rtl/cpu_mem_if.sv
// Memory request/response bundle between the control sequencer (master)
// and the shared single-port memory (slave).
interface cpu_mem_if;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] addr_sel;
  logic       mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 20-bit CPU core: fetch, decode,
// then class-specific EXEC/MEM/WB sequencing with a retired-instruction count.
module cpu_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             alu,
  input  logic             is_imm,
  input  logic             ld,
  input  logic             st,
  input  logic             push,
  input  logic             pop,
  input  logic             jump,
  input  logic             be,
  input  logic             halt,
  input  logic             be_eq,
  cpu_mem_if.master        mem,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             alu_en,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             sp_inc,
  output logic             sp_dec,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // Latched instruction class, already priority-resolved so that at most
  // one memory direction can ever be requested.
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ALU  = 3'd1;
  localparam logic [2:0] OP_LD   = 3'd2;
  localparam logic [2:0] OP_ST   = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [2:0]       op_q;
  logic [2:0]       dec_op;
  logic             dec_pc_load;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  logic             mem_read_c;
  logic             mem_write_c;
  logic [1:0]       addr_sel_c;

  // Operand muxing for immediates belongs to the decoder.
  logic             unused_is_imm;
  assign unused_is_imm = is_imm;

  always_comb begin
    dec_op = OP_NONE;
    if (halt)      dec_op = OP_NONE;
    else if (alu)  dec_op = OP_ALU;
    else if (ld)   dec_op = OP_LD;
    else if (st)   dec_op = OP_ST;
    else if (push) dec_op = OP_PUSH;
    else if (pop)  dec_op = OP_POP;
  end

  // Control-flow ops only reach here when no data-class flag won priority.
  assign dec_pc_load = (dec_op == OP_NONE) && !halt && (jump || (be && be_eq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= dec_op;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (halt) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (dec_op == OP_ALU) begin
          state_d = S_EXEC;
        end else if (dec_op != OP_NONE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_MEM: begin
        if (mem.mem_ready) begin
          if (op_q == OP_LD || op_q == OP_POP) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    addr_sel_c  = 2'd0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_en      = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_load    = mem.mem_ready;
        pc_inc     = mem.mem_ready;
      end
      S_DECODE: begin
        sp_dec  = (dec_op == OP_PUSH);
        pc_load = dec_pc_load;
      end
      S_EXEC:   alu_en = 1'b1;
      S_MEM: begin
        addr_sel_c  = (op_q == OP_PUSH || op_q == OP_POP) ? 2'd2 : 2'd1;
        mem_read_c  = (op_q == OP_LD || op_q == OP_POP);
        mem_write_c = (op_q == OP_ST || op_q == OP_PUSH);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OP_LD || op_q == OP_POP);
        sp_inc    = (op_q == OP_POP);
      end
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign mem.addr_sel  = addr_sel_c;
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized scoreboard bench for cpu_control_fsm: a driver plans each
// instruction from class timing rules, a monitor compares every cycle.
module tb_cpu_control_fsm;
  localparam int CNT_W = 4;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_PUSH = 3, K_POP = 4;
  localparam int K_JMP = 5, K_BE = 6, K_NOP = 7, K_HALT = 8;

  localparam logic [12:0] O_MR  = 13'h1000;
  localparam logic [12:0] O_MW  = 13'h0800;
  localparam logic [12:0] O_AS2 = 13'h0400;
  localparam logic [12:0] O_AS1 = 13'h0200;
  localparam logic [12:0] O_IR  = 13'h0100;
  localparam logic [12:0] O_PI  = 13'h0080;
  localparam logic [12:0] O_PL  = 13'h0040;
  localparam logic [12:0] O_AE  = 13'h0020;
  localparam logic [12:0] O_RW  = 13'h0010;
  localparam logic [12:0] O_WS  = 13'h0008;
  localparam logic [12:0] O_SI  = 13'h0004;
  localparam logic [12:0] O_SD  = 13'h0002;
  localparam logic [12:0] O_H   = 13'h0001;

  typedef logic [15+CNT_W:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, alu, is_imm, ld, st, push, pop, jump, be, halt, be_eq;
  logic ir_load, pc_inc, pc_load, alu_en, reg_write, wb_sel, sp_inc, sp_dec, halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  cpu_mem_if mif ();

  cpu_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu(alu), .is_imm(is_imm), .ld(ld), .st(st), .push(push), .pop(pop),
    .jump(jump), .be(be), .halt(halt), .be_eq(be_eq),
    .mem(mif.master),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_en(alu_en),
    .reg_write(reg_write), .wb_sel(wb_sel), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ret_m  = 0;

  function automatic vec_t pack_dut();
    return {state, mif.mem_read, mif.mem_write, mif.addr_sel, ir_load, pc_inc,
            pc_load, alu_en, reg_write, wb_sel, sp_inc, sp_dec, halted, retired};
  endfunction

  function automatic logic rb();
    return 1'($urandom());
  endfunction

  function automatic logic [8:0] rf();
    return 9'($urandom());
  endfunction

  task automatic check_now(input string name, input vec_t req);
    vec_t got;
    got = pack_dut();
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // One clock cycle: apply inputs just after the edge, record what the
  // outputs must be for this cycle, then advance the retire model.
  task automatic tick(input logic s, input logic rdy, input logic [8:0] fl,
                      input logic eq, input logic [2:0] es, input logic [12:0] eo,
                      input logic ret_ev);
    @(posedge clk);
    #1;
    start = s;
    mif.mem_ready = rdy;
    {alu, is_imm, ld, st, push, pop, jump, be, halt} = fl;
    be_eq = eq;
    exp_q.push_back({es, eo, ret_m[CNT_W-1:0]});
    if (ret_ev) ret_m = (ret_m + 1) % (1 << CNT_W);
  endtask

  task automatic mem_phase(input logic [12:0] eo, input int wm, input logic ret_last);
    for (int i = 0; i < wm; i++) tick(rb(), 1'b0, rf(), rb(), 3'd4, eo, 1'b0);
    tick(rb(), 1'b1, rf(), rb(), 3'd4, eo, ret_last);
  endtask

  function automatic logic [8:0] dec_flags(input int kind);
    logic [8:0] r;
    r = rf();
    case (kind)
      K_ALU:   return 9'h100 | (r & 9'h0FE);
      K_LD:    return 9'h040 | (r & 9'h09E);
      K_ST:    return 9'h020 | (r & 9'h09E);
      K_PUSH:  return 9'h010 | (r & 9'h08E);
      K_POP:   return 9'h008 | (r & 9'h086);
      K_JMP:   return 9'h004 | (r & 9'h082);
      K_BE:    return 9'h002 | (r & 9'h080);
      K_HALT:  return 9'h001 | r;
      default: return r & 9'h080;
    endcase
  endfunction

  task automatic run_instr(input int kind, input logic eq, input int wf, input int wm);
    logic [8:0] fl;
    fl = dec_flags(kind);
    for (int i = 0; i < wf; i++) tick(rb(), 1'b0, rf(), rb(), 3'd1, O_MR, 1'b0);
    tick(rb(), 1'b1, rf(), rb(), 3'd1, O_MR | O_IR | O_PI, 1'b0);
    case (kind)
      K_ALU: begin
        tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b0);
        tick(rb(), rb(), rf(), rb(), 3'd3, O_AE, 1'b0);
        tick(rb(), rb(), rf(), rb(), 3'd5, O_RW, 1'b1);
      end
      K_LD: begin
        tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b0);
        mem_phase(O_MR | O_AS1, wm, 1'b0);
        tick(rb(), rb(), rf(), rb(), 3'd5, O_RW | O_WS, 1'b1);
      end
      K_POP: begin
        tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b0);
        mem_phase(O_MR | O_AS2, wm, 1'b0);
        tick(rb(), rb(), rf(), rb(), 3'd5, O_RW | O_WS | O_SI, 1'b1);
      end
      K_ST: begin
        tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b0);
        mem_phase(O_MW | O_AS1, wm, 1'b1);
      end
      K_PUSH: begin
        tick(rb(), rb(), fl, eq, 3'd2, O_SD, 1'b0);
        mem_phase(O_MW | O_AS2, wm, 1'b1);
      end
      K_JMP:  tick(rb(), rb(), fl, eq, 3'd2, O_PL, 1'b1);
      K_BE:   tick(rb(), rb(), fl, eq, 3'd2, eq ? O_PL : 13'h0, 1'b1);
      K_HALT: tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b1);
      default: tick(rb(), rb(), fl, eq, 3'd2, 13'h0, 1'b1);
    endcase
  endtask

  task automatic idle_then_start(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, rb(), rf(), rb(), 3'd0, 13'h0, 1'b0);
    tick(1'b1, rb(), rf(), rb(), 3'd0, 13'h0, 1'b0);
  endtask

  initial begin : monitor
    vec_t e;
    vec_t g;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = pack_dut();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle_out t=%0t got state=%0d ctl=%h ret=%0d required state=%0d ctl=%h ret=%0d",
                   $time, g[15+CNT_W:13+CNT_W], g[12+CNT_W:CNT_W], g[CNT_W-1:0],
                   e[15+CNT_W:13+CNT_W], e[12+CNT_W:CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin : driver
    start = 1'b0;
    mif.mem_ready = 1'b0;
    {alu, is_imm, ld, st, push, pop, jump, be, halt} = 9'h0;
    be_eq = 1'b0;

    #23;
    check_now("in_reset", '0);
    #4 rst_n = 1'b1;

    idle_then_start(5);
    run_instr(K_ALU, rb(), 0, 0);
    run_instr(K_LD, rb(), 0, 3);
    run_instr(K_PUSH, rb(), 0, 0);
    run_instr(K_POP, rb(), 0, 0);
    run_instr(K_BE, 1'b1, 0, 0);
    run_instr(K_BE, 1'b0, 0, 0);
    run_instr(K_JMP, rb(), 1, 0);
    run_instr(K_NOP, rb(), 0, 0);
    run_instr(K_ST, rb(), 2, 1);

    for (int n = 0; n < 200; n++)
      run_instr($urandom_range(0, 7), rb(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset asserted in the middle of a push's memory wait.
    tick(rb(), 1'b1, rf(), rb(), 3'd1, O_MR | O_IR | O_PI, 1'b0);
    tick(rb(), rb(), dec_flags(K_PUSH), rb(), 3'd2, O_SD, 1'b0);
    tick(rb(), 1'b0, rf(), rb(), 3'd4, O_MW | O_AS2, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mif.mem_write !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got mem_write=%b state=%0d required mem_write=0 state=0",
               mif.mem_write, state);
    end
    check_now("async_reset_all", '0);
    ret_m = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    idle_then_start(3);
    run_instr(K_ALU, rb(), 0, 0);
    run_instr(K_HALT, rb(), 0, 0);
    for (int i = 0; i < 6; i++) tick(i[0], rb(), rf(), rb(), 3'd6, O_H, 1'b0);

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d entries required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
